// File: rtl/rpn_stack_calc_pkg.sv
// Shared types for the RPN stack calculator: opcodes, error codes and control FSM states.
package rpn_pkg;

   typedef enum logic [2:0] {
      OP_NOP  = 3'd0,
      OP_NEG  = 3'd1,
      OP_ADD  = 3'd2,
      OP_MUL  = 3'd3,
      OP_SUB  = 3'd4,
      OP_DUP  = 3'd5,
      OP_SWAP = 3'd6,
      OP_DROP = 3'd7
   } opcode_t;

   typedef enum logic [1:0] {
      ERR_OK  = 2'd0,
      ERR_UNF = 2'd1,
      ERR_OVF = 2'd2
   } err_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/rpn_stack_calc_if.sv
// Command/status bundle between the keypad decoder (master) and the stack calculator (slave).
interface rpn_stack_calc_if #(
   parameter int W     = 16,
   parameter int DEPTH = 1024
);
   localparam int CW = $clog2(DEPTH + 1);

   logic          valid;
   logic          push;
   logic [W-1:0]  d;
   logic [2:0]    op;
   logic          ready;
   logic [CW-1:0] cnt;
   logic [W-1:0]  out;
   logic [1:0]    err;

   modport master (output valid, push, d, op, input ready, cnt, out, err);
   modport slave  (input valid, push, d, op, output ready, cnt, out, err);
endinterface

// File: rtl/rpn_stack_calc_seq_mul.sv
// Iterative shift-add multiplier: loads on start_i, then retires one multiplier bit per clock for W clocks.
module seq_mul #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         nrst,
   input  logic         start_i,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic         done_o,
   output logic [W-1:0] prod_o
);
   localparam int CNTW = (W > 1) ? $clog2(W) : 1;

   logic            busy_q;
   logic [CNTW-1:0] bit_q;
   logic [W-1:0]    mcand_q;
   logic [W-1:0]    mplier_q;
   logic [W-1:0]    acc_q;

   // done_o marks the cycle whose closing edge retires the final bit
   assign done_o = busy_q && (bit_q == CNTW'(W - 1));
   assign prod_o = acc_q;

   // Operand load and shift-add datapath; only the low W product bits are kept
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         busy_q   <= 1'b0;
         bit_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
      end else if (start_i) begin
         busy_q   <= 1'b1;
         bit_q    <= '0;
         mcand_q  <= a_i;
         mplier_q <= b_i;
         acc_q    <= '0;
      end else if (busy_q) begin
         acc_q    <= acc_q + (mplier_q[0] ? mcand_q : {W{1'b0}});
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         bit_q    <= bit_q + CNTW'(1);
         busy_q   <= !done_o;
      end else begin
         busy_q   <= 1'b0;
      end
   end
endmodule

// File: rtl/rpn_stack_calc.sv
// RPN operand stack with single-cycle stack/arithmetic ops and a multi-cycle MUL behind a ready handshake.
module rpn_stack_calc
   import rpn_pkg::*;
#(
   parameter int W     = 16,
   parameter int DEPTH = 1024
) (
   input logic              clk,
   input logic              nrst,
   rpn_stack_calc_if.slave  bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [CW-1:0] cnt_q, cnt_d;
   err_t          err_q, err_d;
   state_t        state_q, state_d;

   logic [AW-1:0] tos_a_s, nos_a_s, new_a_s;
   logic [W-1:0]  tos_s, nos_s;
   logic          accept_s, has1_s, has2_s, full_s;
   logic          we0_s, we1_s, mul_start_s, mul_done_s;
   logic [AW-1:0] wa0_s, wa1_s;
   logic [W-1:0]  wd0_s, wd1_s, prod_s;

   assign tos_a_s  = AW'(cnt_q - CW'(1));
   assign nos_a_s  = AW'(cnt_q - CW'(2));
   assign new_a_s  = AW'(cnt_q);
   assign tos_s    = mem_q[tos_a_s];
   assign nos_s    = mem_q[nos_a_s];
   assign accept_s = bus.valid && (state_q == ST_IDLE);
   assign has1_s   = (cnt_q != CW'(0));
   assign has2_s   = (cnt_q >= CW'(2));
   assign full_s   = (cnt_q == CW'(DEPTH));

   assign bus.ready = (state_q == ST_IDLE);
   assign bus.cnt   = cnt_q;
   assign bus.out   = has1_s ? tos_s : {W{1'b0}};
   assign bus.err   = err_q;

   seq_mul #(.W(W)) u_mul (
      .clk     (clk),
      .nrst    (nrst),
      .start_i (mul_start_s),
      .a_i     (nos_s),
      .b_i     (tos_s),
      .done_o  (mul_done_s),
      .prod_o  (prod_s)
   );

   // Command decode: next depth, error, FSM state and up to two stack writes (SWAP needs both)
   always_comb begin
      cnt_d       = cnt_q;
      err_d       = err_q;
      state_d     = state_q;
      we0_s       = 1'b0;
      wa0_s       = new_a_s;
      wd0_s       = bus.d;
      we1_s       = 1'b0;
      wa1_s       = nos_a_s;
      wd1_s       = tos_s;
      mul_start_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!accept_s) begin
               state_d = ST_IDLE;
            end else if (bus.push) begin
               if (full_s) begin
                  err_d = ERR_OVF;
               end else begin
                  we0_s = 1'b1;
                  cnt_d = cnt_q + CW'(1);
                  err_d = ERR_OK;
               end
            end else begin
               err_d = ERR_OK;
               case (opcode_t'(bus.op))
                  OP_NOP: err_d = ERR_OK;
                  OP_NEG: begin
                     if (!has1_s) begin
                        err_d = ERR_UNF;
                     end else begin
                        we0_s = 1'b1;
                        wa0_s = tos_a_s;
                        wd0_s = {W{1'b0}} - tos_s;
                     end
                  end
                  OP_ADD, OP_SUB: begin
                     if (!has2_s) begin
                        err_d = ERR_UNF;
                     end else begin
                        we0_s = 1'b1;
                        wa0_s = nos_a_s;
                        wd0_s = (bus.op == OP_ADD) ? (nos_s + tos_s) : (nos_s - tos_s);
                        cnt_d = cnt_q - CW'(1);
                     end
                  end
                  OP_MUL: begin
                     if (!has2_s) begin
                        err_d = ERR_UNF;
                     end else begin
                        mul_start_s = 1'b1;
                        state_d     = ST_MUL;
                     end
                  end
                  OP_DUP: begin
                     if (!has1_s) begin
                        err_d = ERR_UNF;
                     end else if (full_s) begin
                        err_d = ERR_OVF;
                     end else begin
                        we0_s = 1'b1;
                        wd0_s = tos_s;
                        cnt_d = cnt_q + CW'(1);
                     end
                  end
                  OP_SWAP: begin
                     if (!has2_s) begin
                        err_d = ERR_UNF;
                     end else begin
                        we0_s = 1'b1;
                        wa0_s = tos_a_s;
                        wd0_s = nos_s;
                        we1_s = 1'b1;
                     end
                  end
                  OP_DROP: begin
                     if (!has1_s) begin
                        err_d = ERR_UNF;
                     end else begin
                        cnt_d = cnt_q - CW'(1);
                     end
                  end
                  default: err_d = ERR_OK;
               endcase
            end
         end
         ST_MUL: begin
            if (mul_done_s) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_MUL;
            end
         end
         ST_DONE: begin
            we0_s   = 1'b1;
            wa0_s   = nos_a_s;
            wd0_s   = prod_s;
            cnt_d   = cnt_q - CW'(1);
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control registers; reset empties the stack and aborts any multiply
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         cnt_q   <= '0;
         err_q   <= ERR_OK;
         state_q <= ST_IDLE;
      end else begin
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         state_q <= state_d;
      end
   end

   // Stack storage carries no reset: entries above cnt are never observed
   always_ff @(posedge clk) begin
      if (we0_s) begin
         mem_q[wa0_s] <= wd0_s;
      end
      if (we1_s) begin
         mem_q[wa1_s] <= wd1_s;
      end
   end
endmodule

// File: tb/tb_rpn_stack_calc.sv
// Directed scoreboard bench for rpn_stack_calc at W=16, DEPTH=8.
module tb_rpn_stack_calc;
   import rpn_pkg::*;

   typedef struct {
      string       tag;
      logic [15:0] out;
      logic [3:0]  cnt;
      logic [1:0]  err;
   } exp_t;

   logic clk = 1'b0;
   logic nrst = 1'b0;
   int   tests = 0;
   int   fails = 0;
   exp_t sb[$];

   rpn_stack_calc_if #(.W(16), .DEPTH(8)) bus ();

   rpn_stack_calc #(.W(16), .DEPTH(8)) dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_st(input string tag, input logic [15:0] o, input logic [3:0] c, input logic [1:0] e);
      exp_t x;
      x.tag = tag; x.out = o; x.cnt = c; x.err = e;
      sb.push_back(x);
   endtask

   task automatic check_st();
      exp_t x;
      if (sb.size() == 0) begin
         cmp("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         x = sb.pop_front();
         cmp({x.tag, ".out"}, 32'(bus.out), 32'(x.out));
         cmp({x.tag, ".cnt"}, 32'(bus.cnt), 32'(x.cnt));
         cmp({x.tag, ".err"}, 32'(bus.err), 32'(x.err));
      end
   endtask

   task automatic drive(input logic p, input logic [15:0] dv, input logic [2:0] o);
      @(negedge clk);
      bus.valid = 1'b1; bus.push = p; bus.d = dv; bus.op = o;
      @(posedge clk);
      #1;
      bus.valid = 1'b0;
   endtask

   task automatic cmd(input string tag, input logic p, input logic [15:0] dv, input logic [2:0] o,
                      input logic [15:0] eo, input logic [3:0] ec, input logic [1:0] ee);
      expect_st(tag, eo, ec, ee);
      drive(p, dv, o);
      check_st();
   endtask

   initial begin
      int n;
      bus.valid = 1'b0; bus.push = 1'b0; bus.d = 16'h0000; bus.op = 3'd0;
      #12;
      cmp("reset.ready", 32'(bus.ready), 32'd1);
      expect_st("reset", 16'h0000, 4'd0, 2'd0);
      check_st();
      @(negedge clk) nrst = 1'b1;

      // add / sub
      cmd("p3",  1'b1, 16'd3,  OP_NOP, 16'd3,  4'd1, 2'd0);
      cmd("p4",  1'b1, 16'd4,  OP_NOP, 16'd4,  4'd2, 2'd0);
      cmd("add", 1'b0, 16'd0,  OP_ADD, 16'd7,  4'd1, 2'd0);
      cmd("p10", 1'b1, 16'd10, OP_NOP, 16'd10, 4'd2, 2'd0);
      cmd("sub", 1'b0, 16'd0,  OP_SUB, 16'hFFFD, 4'd1, 2'd0);
      cmd("drop0", 1'b0, 16'd0, OP_DROP, 16'd0, 4'd0, 2'd0);

      // multiply with busy-period pokes
      cmd("p5",  1'b1, 16'd5,    OP_NOP, 16'd5,    4'd1, 2'd0);
      cmd("pm2", 1'b1, 16'hFFFE, OP_NOP, 16'hFFFE, 4'd2, 2'd0);
      expect_st("mul_acc", 16'hFFFE, 4'd2, 2'd0);
      expect_st("mul_res", 16'hFFF6, 4'd1, 2'd0);
      drive(1'b0, 16'd0, OP_MUL);
      cmp("mul_acc.ready", 32'(bus.ready), 32'd0);
      check_st();
      bus.valid = 1'b1; bus.push = 1'b1; bus.d = 16'h1234;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         n++;
         if (n == 8) begin
            cmp("mul_busy.cnt", 32'(bus.cnt), 32'd2);
            cmp("mul_busy.out", 32'(bus.out), 32'hFFFE);
         end
         if (bus.ready) break;
      end
      bus.valid = 1'b0;
      cmp("mul_busy_cycles", 32'(n), 32'd17);
      check_st();
      cmd("drop1", 1'b0, 16'd0, OP_DROP, 16'd0, 4'd0, 2'd0);

      // swap / dup / drop
      cmd("p1",   1'b1, 16'd1, OP_NOP,  16'd1, 4'd1, 2'd0);
      cmd("p2",   1'b1, 16'd2, OP_NOP,  16'd2, 4'd2, 2'd0);
      cmd("swap", 1'b0, 16'd0, OP_SWAP, 16'd1, 4'd2, 2'd0);
      cmd("dup",  1'b0, 16'd0, OP_DUP,  16'd1, 4'd3, 2'd0);
      cmd("dropa", 1'b0, 16'd0, OP_DROP, 16'd1, 4'd2, 2'd0);
      cmd("dropb", 1'b0, 16'd0, OP_DROP, 16'd2, 4'd1, 2'd0);
      cmd("dropc", 1'b0, 16'd0, OP_DROP, 16'd0, 4'd0, 2'd0);

      // fill to DEPTH, overflow, then ops on a full stack
      for (int i = 1; i <= 8; i++)
         cmd("fill", 1'b1, 16'(i), OP_NOP, 16'(i), 4'(i), 2'd0);
      cmd("ovf_push", 1'b1, 16'd9, OP_NOP, 16'd8,  4'd8, 2'd2);
      cmd("ovf_dup",  1'b0, 16'd0, OP_DUP, 16'd8,  4'd8, 2'd2);
      cmd("full_add", 1'b0, 16'd0, OP_ADD, 16'd15, 4'd7, 2'd0);
      for (int i = 6; i >= 0; i--)
         cmd("drain", 1'b0, 16'd0, OP_DROP, 16'(i), 4'(i), 2'd0);

      // underflow, NOP clear, push-over-op priority, NEG of min value
      cmd("unf_neg", 1'b0, 16'd0, OP_NEG,  16'd0, 4'd0, 2'd1);
      cmd("unf_mul", 1'b0, 16'd0, OP_MUL,  16'd0, 4'd0, 2'd1);
      cmd("unf_mul.ready", 1'b0, 16'd0, OP_NOP, 16'd0, 4'd0, 2'd0);
      cmd("p7",      1'b1, 16'd7, OP_NOP,  16'd7, 4'd1, 2'd0);
      cmd("unf_add", 1'b0, 16'd0, OP_ADD,  16'd7, 4'd1, 2'd1);
      cmd("nop",     1'b0, 16'd0, OP_NOP,  16'd7, 4'd1, 2'd0);
      cmd("neg7",    1'b0, 16'd0, OP_NEG,  16'hFFF9, 4'd1, 2'd0);
      cmd("drop7",   1'b0, 16'd0, OP_DROP, 16'd0, 4'd0, 2'd0);
      cmd("push_pri", 1'b1, 16'h8000, OP_DROP, 16'h8000, 4'd1, 2'd0);
      cmd("neg_min", 1'b0, 16'd0, OP_NEG,  16'h8000, 4'd1, 2'd0);
      cmd("drop8",   1'b0, 16'd0, OP_DROP, 16'd0, 4'd0, 2'd0);

      // reset in the middle of a multiply
      cmd("rp3", 1'b1, 16'd3, OP_NOP, 16'd3, 4'd1, 2'd0);
      cmd("rp4", 1'b1, 16'd4, OP_NOP, 16'd4, 4'd2, 2'd0);
      drive(1'b0, 16'd0, OP_MUL);
      cmp("rmul.ready", 32'(bus.ready), 32'd0);
      repeat (5) @(posedge clk);
      #2 nrst = 1'b0;
      #1;
      cmp("rst_mid.ready", 32'(bus.ready), 32'd1);
      expect_st("rst_mid", 16'd0, 4'd0, 2'd0);
      check_st();
      @(negedge clk) nrst = 1'b1;
      cmd("post_rst", 1'b1, 16'd2, OP_NOP, 16'd2, 4'd1, 2'd0);

      cmp("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/rpn_stack_calc.md
Name: rpn_stack_calc

Overview:
- Parametrised successor of the team's RPN stack calculator.
- Holds a LIFO operand stack of DEPTH words of W bits and executes one command per accepted strobe.
- Command set: push, plus eight stack/arithmetic ops, including an iterative multi-cycle multiply.
- Adds a ready/busy handshake and error reporting, and sits behind the keypad/command decoder in the calculator datapath.

Parameters:
- W, 16, operand width in bits (two's complement).
- DEPTH, 1024, stack capacity in words; any value >= 2.
- CW, $clog2(DEPTH+1), width of the depth counter (derived, not overridable).

Ports:
- clk  in  1  system clock, rising edge.
- nrst  in  1  reset, asynchronous, active-low.
- valid  in  1  command strobe; sampled only when ready=1.
- push  in  1  1 = push d, 0 = execute op.
- d  in  W  operand for push.
- op  in  3  opcode: 0 NOP, 1 NEG, 2 ADD, 3 MUL, 4 SUB, 5 DUP, 6 SWAP, 7 DROP.
- ready  out  1  block can accept a command (= !busy).
- cnt  out  CW  current stack depth.
- out  out  W  top of stack (TOS); 0 when cnt==0.
- err  out  2  result of last accepted command: 0 OK, 1 underflow, 2 overflow.

Behaviour:
- Reset (nrst=0, asynchronous): cnt=0, err=0, ready=1, any multiply aborted, out=0. Memory contents are don't-care.
- Command accept: accepted on a rising clk when valid && ready. When ready=0, valid is ignored; there is no queuing.
- Priority: push=1 overrides op.
- TOS = mem[cnt-1], NOS = mem[cnt-2].
- `out` is combinational from the stack and reflects state after every edge.
- Single-cycle commands complete on the accepting edge:
  - PUSH: mem[cnt] <= d, cnt+1. Needs cnt<DEPTH.
  - NEG: TOS <= -TOS. Needs cnt>=1.
  - ADD: NOS <= NOS+TOS, cnt-1. Needs cnt>=2.
  - SUB: NOS <= NOS-TOS, cnt-1. Needs cnt>=2.
  - DUP: mem[cnt] <= TOS, cnt+1. Needs 1<=cnt<DEPTH.
  - SWAP: exchange TOS and NOS. Needs cnt>=2.
  - DROP: cnt-1. Needs cnt>=1.
  - NOP: no state change; err <= 0.
- Arithmetic is modulo 2^W with no saturation. NEG of the most negative value returns itself.
- MUL uses an FSM with states IDLE, MUL, DONE:
  - Accept edge: latch NOS and TOS, go to MUL, ready=0.
  - Shift-add over W cycles, one bit per clk.
  - Next edge: DONE, which writes NOS <= low W bits of the product, cnt-1, returns to IDLE, ready=1.
  - ready is low for exactly W+1 cycles after the accept edge.
  - cnt and out keep their pre-MUL values until the DONE edge.
- err is updated on every accepted command and held until the next one. err=OK on success.
- Precondition failure: the command has no effect on the stack or cnt. err=1 for too few operands; err=2 for PUSH/DUP at cnt==DEPTH. MUL failure is detected at accept, with no busy period.
- Boundaries:
  - cnt never wraps.
  - A full stack still accepts ops that do not grow it.
  - Simultaneous push and op: push executes, op ignored.
  - Reset mid-MUL: immediate abort, stack emptied.

Decomposition:
- Package rpn_pkg: typedef enum logic [2:0] opcode_t (the eight ops), typedef enum logic [1:0] err_t (OK, UNF, OVF), typedef of the FSM state.
- One sub-module, seq_mul: parametrised W, start/done handshake, W-cycle shift-add, with its own asynchronous nrst. The top block holds the stack memory, cnt, FSM and err.

Test Plan (W=16, DEPTH=8):
- push 3, push 4, ADD -> out=7, cnt=1, err=0. Then push 10, SUB -> out=0xFFFD (-3), cnt=1.
- push 5, push 0xFFFE, MUL -> ready=0 for 17 cycles, valid during busy ignored. Then out=0xFFF6, cnt=1, err=0.
- push 1, push 2, SWAP -> out=1, cnt=2. DUP -> out=1, cnt=3. DROP, DROP -> out=2, cnt=1.
- 8 pushes of 1..8, 9th push 9 -> err=2, cnt=8, out=8. Then DUP -> err=2. Then ADD -> out=15, cnt=7, err=0.
- Empty stack NEG -> err=1, cnt=0, out=0. Push 7, ADD -> err=1, cnt=1, out=7. Push 0x8000, NEG -> out=0x8000.
- Push 3, push 4, MUL, assert nrst=0 at busy cycle 5 -> cnt=0, ready=1, err=0, out=0 immediately. After release, push 2 -> out=2, cnt=1.
